// File: rtl/alu_pipe_cc_if.sv
// alu_pipe_cc_if: request/result handshake bundle for alu_pipe_cc
interface alu_pipe_cc_if #(parameter int WIDTH = 64);
  logic in_valid, in_ready, set_cc, out_valid, out_ready, out_err;
  logic [2:0] op, cc;
  logic [WIDTH-1:0] a, b, result;
  modport master(output in_valid, op, a, b, set_cc, out_ready, input in_ready, out_valid, result, out_err, cc);
  modport slave(input in_valid, op, a, b, set_cc, out_ready, output in_ready, out_valid, result, out_err, cc);
endinterface

// File: rtl/alu_pipe_cc.sv
// alu_pipe_cc: registered Y86 ALU with {ZF,SF,OF} condition codes; ALU_MUL_EN adds an iterative multiply (op 4)
module alu_pipe_cc #(
  parameter int WIDTH = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input logic clk,
  input logic rst_n,
  alu_pipe_cc_if.slave bus
);
  logic [WIDTH-1:0] sum, dif, r;
  logic of, legal, acc, idle, mul_go, mul_done;
  logic [WIDTH-1:0] mp;
  logic msc;
  always_comb begin
    sum = bus.b + bus.a;
    dif = bus.b - bus.a;
    legal = bus.op < 3'd4;
    r = bus.op == 3'd0 ? sum : bus.op == 3'd1 ? dif : bus.op == 3'd2 ? bus.b & bus.a : bus.op == 3'd3 ? bus.b ^ bus.a : '0;
    of = bus.op == 3'd0 ? (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.b[WIDTH-1]) :
         bus.op == 3'd1 ? (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.b[WIDTH-1]) : 1'b0;
  end
  assign bus.in_ready = idle && (!bus.out_valid || bus.out_ready);
  assign acc = bus.in_valid && bus.in_ready;
`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] mcand, mplier, prod;
  logic [CW-1:0] cnt;
  assign idle = state == IDLE;
  assign mul_go = acc && bus.op == 3'd4;
  assign mul_done = state == BUSY && cnt == CW'(WIDTH - 1);
  assign mp = prod + (mplier[0] ? mcand : '0);
  always_comb begin
    state_nx = mul_go ? BUSY : mul_done ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    state <= !rst_n ? IDLE : state_nx;
  end
  // one multiplier bit per BUSY cycle; the final partial sum goes straight into result
  always_ff @(posedge clk) begin
    if (mul_go) begin
      mcand <= bus.a;
      mplier <= bus.b;
      prod <= '0;
      cnt <= '0;
      msc <= bus.set_cc;
    end else if (state == BUSY) begin
      prod <= mp;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign idle = 1'b1;
  assign mul_go = 1'b0;
  assign mul_done = 1'b0;
  assign mp = '0;
  assign msc = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result <= '0;
      bus.out_err <= 1'b0;
      bus.cc <= CC_RESET;
    end else if (acc && !mul_go) begin
      bus.out_valid <= 1'b1;
      bus.result <= r;
      bus.out_err <= !legal;
      if (legal && bus.set_cc) bus.cc <= {r == '0, r[WIDTH-1], of};
    end else if (mul_done) begin
      bus.out_valid <= 1'b1;
      bus.result <= mp;
      bus.out_err <= 1'b0;
      if (msc) bus.cc <= {mp == '0, mp[WIDTH-1], 1'b0};
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe_cc.sv
// tb_alu_pipe_cc: scoreboard bench for alu_pipe_cc at WIDTH=64
module tb_alu_pipe_cc;
  typedef struct {logic [63:0] r; logic e; logic [2:0] c;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic took;
  logic [2:0] mcc = 3'b100;
  exp_t sb[$];
  alu_pipe_cc_if #(.WIDTH(64)) bus();
  alu_pipe_cc #(.WIDTH(64), .CC_RESET(3'b100)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic push_model();
    logic [63:0] x, y, r;
    logic of, lg;
    x = bus.a;
    y = bus.b;
    of = 1'b0;
    lg = 1'b1;
    case (bus.op)
      3'd0: begin r = y + x; of = (x[63] == y[63]) && (r[63] != y[63]); end
      3'd1: begin r = y - x; of = (x[63] != y[63]) && (r[63] != y[63]); end
      3'd2: r = y & x;
      3'd3: r = y ^ x;
`ifdef ALU_MUL_EN
      3'd4: r = y * x;
`endif
      default: begin r = '0; lg = 1'b0; end
    endcase
    if (lg && bus.set_cc) mcc = {r == 64'd0, r[63], of};
    sb.push_back('{r, !lg, mcc});
  endtask
  task automatic tick();
    exp_t e;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = sb.pop_front();
        chk("result", bus.result, e.r);
        chk("out_err", bus.out_err, e.e);
        chk("cc", bus.cc, e.c);
      end
    end
    took = bus.in_valid && bus.in_ready;
    if (took) push_model();
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drive(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y, input logic s);
    int n = 0;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.set_cc = s;
    bus.in_valid = 1'b1;
    do begin tick(); n++; end while (!took && n < 200);
    if (!took) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask
  initial begin
    int c0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    bus.set_cc = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_cc", bus.cc, 3'b100);
    rst_n = 1'b1;
    drive(3'd0, 64'd1, 64'd2, 1'b1);
    drive(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    drive(3'd3, 64'hA5A5, 64'hA5A5, 1'b0);
    drive(3'd1, 64'd5, 64'd5, 1'b1);
    drive(3'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    drive(3'd3, 64'hA5A5, 64'hA5A5, 1'b1);
    drive(3'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1);
    drive(3'd6, 64'd1, 64'd1, 1'b1);
    drive(3'd7, 64'd3, 64'd9, 1'b1);
    drive(3'd1, 64'd7, 64'd3, 1'b1);
    repeat (3) tick();
    bus.out_ready = 1'b0;
    drive(3'd2, 64'hFF00, 64'h0FF0, 1'b1);
    bus.op = 3'd1;
    bus.a = 64'd2;
    bus.b = 64'd9;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_result", bus.result, 64'h0F00);
      tick();
    end
    bus.out_ready = 1'b1;
    c0 = cyc;
    drive(3'd1, 64'd2, 64'd9, 1'b1);
    drive(3'd2, 64'hF0F0, 64'h3C3C, 1'b0);
    drive(3'd1, 64'd9, 64'd2, 1'b1);
    drive(3'd2, 64'd0, 64'hFFFF, 1'b1);
    drive(3'd0, 64'h1234, 64'h4321, 1'b1);
    drive(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    chk("throughput", cyc - c0, 6);
    repeat (2) tick();
`ifdef ALU_MUL_EN
    begin
      int busy = 0;
      logic seen = 1'b0;
      drive(3'd4, 64'd13, 64'd11, 1'b1);
      for (int i = 0; i < 200 && !bus.out_valid; i++) begin
        busy += int'(!bus.in_ready);
        tick();
      end
      chk("mul_busy", busy, 64);
      repeat (2) tick();
      drive(3'd4, 64'd13, 64'd11, 1'b1);
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      void'(sb.pop_back());
      mcc = 3'b100;
      chk("abort_valid", bus.out_valid, 0);
      chk("abort_idle", bus.in_ready, 1);
      for (int i = 0; i < 70; i++) begin
        seen |= bus.out_valid;
        tick();
      end
      chk("abort_no_out", seen, 0);
    end
`else
    drive(3'd4, 64'd13, 64'd11, 1'b1);
    repeat (2) tick();
`endif
    chk("drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
